// File: rtl/ram_1r1w_queue_ctrl.sv
// Circular-queue controller for an external 1R1W RAM (combinational read, posedge write) with a show-ahead FIFO view.
// Optional feature: define QUEUE_ALMOST_FULL_EN to add a registered almost_full_o asserted at AF_THRESH entries.
module ram_1r1w_queue_ctrl #(
  parameter int DEPTH     = 64,
  parameter int INDEX     = 6,
  parameter int WIDTH     = 32
`ifdef QUEUE_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = 56
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [INDEX:0]   count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [INDEX-1:0] ram_rd_addr_o,
  output logic [INDEX-1:0] ram_wr_addr_o,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_wr_data_o,
  input  logic [WIDTH-1:0] ram_rd_data_i
`ifdef QUEUE_ALMOST_FULL_EN
  ,
  output logic             almost_full_o
`endif
);

  localparam logic [INDEX:0]   C_DEPTH = (INDEX+1)'(DEPTH);
  localparam logic [INDEX-1:0] C_LAST  = INDEX'(DEPTH - 1);

  logic [INDEX-1:0] r_head;
  logic [INDEX-1:0] r_tail;
  logic [INDEX:0]   r_count;
  logic [INDEX:0]   w_count_next;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers wrap at DEPTH-1, not at 2^INDEX, so non-power-of-two depths work.
  function automatic logic [INDEX-1:0] f_advance(input logic [INDEX-1:0] ptr);
    return (ptr == C_LAST) ? '0 : ptr + INDEX'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop_ok  = pop_i & ~w_empty;
  assign w_push_ok = push_i & (~w_full | w_pop_ok);

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + (INDEX+1)'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_next = r_count - (INDEX+1)'(1);
    end
  end

  // NOTE: only pointers, count and flags are reset; the RAM array keeps stale data, which is never exposed because count drops to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_count <= w_count_next;
      if (flush_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_pop_ok)  r_head <= f_advance(r_head);
        if (w_push_ok) r_tail <= f_advance(r_tail);
      end
      if (push_i && !w_push_ok) r_overflow  <= 1'b1;
      if (pop_i  && !w_pop_ok)  r_underflow <= 1'b1;
    end
  end

`ifdef QUEUE_ALMOST_FULL_EN
  localparam logic [INDEX:0] C_AF_THRESH = (INDEX+1)'(AF_THRESH);

  logic r_almost_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_almost_full <= 1'b0;
    end else if (flush_i) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= C_AF_THRESH);
    end
  end

  assign almost_full_o = r_almost_full;
`endif

  assign pop_data_o    = ram_rd_data_i;
  assign empty_o       = w_empty;
  assign full_o        = w_full;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;
  assign ram_rd_addr_o = r_head;
  assign ram_wr_addr_o = r_tail;
  assign ram_we_o      = w_push_ok & ~flush_i;
  assign ram_wr_data_o = push_data_i;

endmodule

// File: tb/tb_ram_1r1w_queue_ctrl.sv
// Directed bench for ram_1r1w_queue_ctrl (DEPTH=6) with a queue-based reference model and per-cycle compare.
// Define QUEUE_ALMOST_FULL_EN to also check almost_full_o with AF_THRESH=4.
module tb_ram_1r1w_queue_ctrl;

  localparam int DEPTH = 6;
  localparam int INDEX = 3;
  localparam int WIDTH = 8;
  localparam int AF    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush_i;
  logic             push_i;
  logic [WIDTH-1:0] push_data_i;
  logic             pop_i;
  logic [WIDTH-1:0] pop_data_o;
  logic             empty_o;
  logic             full_o;
  logic [INDEX:0]   count_o;
  logic             overflow_o;
  logic             underflow_o;
  logic [INDEX-1:0] ram_rd_addr_o;
  logic [INDEX-1:0] ram_wr_addr_o;
  logic             ram_we_o;
  logic [WIDTH-1:0] ram_wr_data_o;
  logic [WIDTH-1:0] ram_rd_data_i;
`ifdef QUEUE_ALMOST_FULL_EN
  logic             almost_full_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  ram_1r1w_queue_ctrl #(
    .DEPTH(DEPTH),
    .INDEX(INDEX),
    .WIDTH(WIDTH)
`ifdef QUEUE_ALMOST_FULL_EN
    ,
    .AF_THRESH(AF)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(flush_i),
    .push_i(push_i),
    .push_data_i(push_data_i),
    .pop_i(pop_i),
    .pop_data_o(pop_data_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .underflow_o(underflow_o),
    .ram_rd_addr_o(ram_rd_addr_o),
    .ram_wr_addr_o(ram_wr_addr_o),
    .ram_we_o(ram_we_o),
    .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_data_i(ram_rd_data_i)
`ifdef QUEUE_ALMOST_FULL_EN
    ,
    .almost_full_o(almost_full_o)
`endif
  );

  always #5 clk = ~clk;

  // RAM fixture: combinational read, posedge write.
  logic [WIDTH-1:0] mem [2**INDEX];
  assign ram_rd_data_i = mem[ram_rd_addr_o];
  always @(posedge clk) if (ram_we_o) mem[ram_wr_addr_o] <= ram_wr_data_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted entries plus head/tail slot numbers.
  logic [WIDTH-1:0] q[$];
  int m_head = 0;
  int m_tail = 0;
  bit m_ovf  = 1'b0;
  bit m_udf  = 1'b0;
  bit m_af   = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    bit can_pop;
    bit can_push;
    if (!reset_n) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_af   = 1'b0;
    end else begin
      can_pop  = pop_i && (q.size() != 0);
      can_push = push_i && ((q.size() != DEPTH) || can_pop);
      if (push_i && !can_push) m_ovf = 1'b1;
      if (pop_i && !can_pop)   m_udf = 1'b1;
      if (flush_i) begin
        q.delete();
        m_head = 0;
        m_tail = 0;
      end else begin
        if (can_pop) begin
          void'(q.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
        if (can_push) begin
          q.push_back(push_data_i);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
      m_af = (q.size() >= AF);
    end
  end

  // Per-cycle compare, mid-cycle after the inputs for this cycle are applied.
  always @(negedge clk) begin
    bit exp_we;
    if (chk_en && reset_n) begin
      exp_we = push_i && !flush_i &&
               ((q.size() < DEPTH) || (pop_i && q.size() != 0));
      check("cyc_empty", empty_o, q.size() == 0);
      check("cyc_full", full_o, q.size() == DEPTH);
      check("cyc_count", count_o, q.size());
      check("cyc_overflow", overflow_o, m_ovf);
      check("cyc_underflow", underflow_o, m_udf);
      check("cyc_rd_addr", ram_rd_addr_o, m_head);
      check("cyc_wr_addr", ram_wr_addr_o, m_tail);
      check("cyc_we", ram_we_o, exp_we);
      check("cyc_wr_data", ram_wr_data_o, push_data_i);
      if (q.size() != 0) check("cyc_pop_data", pop_data_o, q[0]);
`ifdef QUEUE_ALMOST_FULL_EN
      check("cyc_almost_full", almost_full_o, m_af);
`endif
    end
  end

  task automatic set(input bit push, input logic [WIDTH-1:0] data, input bit pop, input bit flush);
    push_i      = push;
    push_data_i = data;
    pop_i       = pop;
    flush_i     = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_count", count_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_underflow", underflow_o, 0);
    check("rst_rd_addr", ram_rd_addr_o, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // Fill, then one dropped push.
    for (int i = 0; i < DEPTH; i++) begin
      set(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set(1'b0, '0, 1'b0, 1'b0);
    check("t1_full", full_o, 1);
    check("t1_count", count_o, 6);
    set(1'b1, 8'hA6, 1'b0, 1'b0);
    #2 check("t1_we_dropped", ram_we_o, 0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t1_overflow", overflow_o, 1);
    check("t1_count_hold", count_o, 6);

    // Drain in order, head wraps 5 -> 0.
    for (int i = 0; i < DEPTH; i++) begin
      set(1'b0, '0, 1'b1, 1'b0);
      #2;
      check("t2_pop_data", pop_data_o, 8'hA0 + 8'(i));
      check("t2_rd_addr", ram_rd_addr_o, i);
      tick();
    end
    set(1'b0, '0, 1'b0, 1'b0);
    check("t2_empty", empty_o, 1);
    check("t2_rd_wrap", ram_rd_addr_o, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) begin
      set(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set(1'b1, 8'hB0, 1'b1, 1'b0);
    #2;
    check("t3_pop_old", pop_data_o, 8'hA0);
    check("t3_we", ram_we_o, 1);
    check("t3_wr_addr", ram_wr_addr_o, 0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t3_count", count_o, 6);
    check("t3_mem0", mem[0], 8'hB0);
    for (int i = 1; i < DEPTH; i++) begin
      set(1'b0, '0, 1'b1, 1'b0);
      #2 check("t3_pop_data", pop_data_o, 8'hA0 + 8'(i));
      tick();
    end
    set(1'b0, '0, 1'b0, 1'b0);
    check("t3_pop_b0", pop_data_o, 8'hB0);
    set(1'b0, '0, 1'b1, 1'b0);
    tick();

    // Empty with simultaneous push and pop.
    set(1'b1, 8'h11, 1'b1, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t4_underflow", underflow_o, 1);
    check("t4_count", count_o, 1);
    check("t4_pop_data", pop_data_o, 8'h11);
    set(1'b0, '0, 1'b1, 1'b0);
    tick();

    // Flush beats a concurrent push; sticky flags survive.
    for (int i = 0; i < 3; i++) begin
      set(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set(1'b1, 8'hD0, 1'b0, 1'b1);
    #2 check("t5_we_flush", ram_we_o, 0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t5_count", count_o, 0);
    check("t5_empty", empty_o, 1);
    check("t5_overflow", overflow_o, 1);
    check("t5_underflow", underflow_o, 1);
    check("t5_wr_addr", ram_wr_addr_o, 0);
    set(1'b1, 8'hE0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t5_pop_data", pop_data_o, 8'hE0);
    set(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Almost-full threshold, then asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      set(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      tick();
`ifdef QUEUE_ALMOST_FULL_EN
      check("t6_af_fill", almost_full_o, (i == 3));
`endif
    end
    set(1'b0, '0, 1'b1, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t6_count", count_o, 3);
`ifdef QUEUE_ALMOST_FULL_EN
    check("t6_af_pop", almost_full_o, 0);
`endif
    set(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
`ifdef QUEUE_ALMOST_FULL_EN
    check("t6_af_again", almost_full_o, 1);
`endif
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_count", count_o, 0);
    check("t6_rst_overflow", overflow_o, 0);
    check("t6_rst_underflow", underflow_o, 0);
`ifdef QUEUE_ALMOST_FULL_EN
    check("t6_rst_af", almost_full_o, 0);
`endif
    tick();
    check("t6_rst_hold_empty", empty_o, 1);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    set(1'b1, 8'hF0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, 1'b0);
    check("t6_post_pop_data", pop_data_o, 8'hF0);
    check("t6_post_rd_addr", ram_rd_addr_o, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_1r1w_queue_ctrl.md
Name: ram_1r1w_queue_ctrl

Overview:
Circular-queue controller that drives both ports of a 1-read/1-write RAM macro and presents a show-ahead FIFO interface. It sits beside a RAM instance that has a combinational read and a posedge write, and owns all address, write-enable and occupancy state. Producers push on one side and consumers pop on the other. The RAM array stays a separate instance, so the storage can be swapped for a compiled macro.

Parameters:
DEPTH, 64, number of queue entries; any value from 2 to 2^INDEX, power of two not required.
INDEX, 6, RAM address width.
WIDTH, 32, data width.
AF_THRESH, 56, almost-full level; only used when QUEUE_ALMOST_FULL_EN is defined.

Ports:
clk  in  1  clock; all state updates on posedge.
reset_n  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous clear of the queue.
push_i  in  1  push request.
push_data_i  in  WIDTH  data to enqueue.
pop_i  in  1  pop request.
pop_data_o  out  WIDTH  head entry (show-ahead); equals ram_rd_data_i.
empty_o  out  1  queue empty.
full_o  out  1  queue full.
count_o  out  INDEX+1  occupancy, 0..DEPTH.
overflow_o  out  1  sticky: a push was dropped.
underflow_o  out  1  sticky: a pop was dropped.
ram_rd_addr_o  out  INDEX  RAM read address; always equals head.
ram_wr_addr_o  out  INDEX  RAM write address; always equals tail.
ram_we_o  out  1  RAM write enable.
ram_wr_data_o  out  WIDTH  RAM write data; equals push_data_i.
ram_rd_data_i  in  WIDTH  RAM combinational read data.
almost_full_o  out  1  present only with QUEUE_ALMOST_FULL_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: head=0, tail=0, count=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
- State is head, tail and count registers. empty_o is (count==0) and full_o is (count==DEPTH); both are decoded from count, not from a pointer comparison.
- push_ok = push_i & (~full_o | pop_ok).
- pop_ok = pop_i & ~empty_o.
- ram_we_o = push_ok & ~flush_i; it is a purely combinational decode.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. There is no modulo 2^INDEX wrap.
- count update: count_next = count + push_ok - pop_ok.
- Latency:
  - A pushed entry is visible on pop_data_o the cycle after the push edge when the queue was empty (the RAM write lands at that edge).
  - A pop advances head at the edge; the next entry is valid in the following cycle with no bubble.
- Full & push & pop: both are accepted. The write goes to tail, which equals head. The read returns the old head data before the edge, count stays DEPTH, and both pointers advance.
- Empty & push & pop: the pop is dropped and underflow_o is set; the push is accepted and count becomes 1.
- Full & push & ~pop: the push is dropped, ram_we_o=0 and overflow_o is set.
- Empty & pop: underflow_o is set and head is unchanged. pop_data_o is don't-care while empty_o=1.
- flush_i has priority over push and pop in the same cycle. It sets head=tail=0 and count=0 and suppresses ram_we_o. overflow_o and underflow_o are not cleared by flush; only reset_n clears them.
- Asynchronous reset asserted mid-stream: all state clears immediately and RAM contents become stale. Outputs must not glitch to the non-empty state after reset is released.

Optional Feature:
- Macro: QUEUE_ALMOST_FULL_EN.
- Defined: almost_full_o port exists and is registered. It is 1 when count_next >= AF_THRESH, resets to 0, and is cleared by flush.
- Undefined: the port and its logic are absent, and AF_THRESH is ignored.

Test Plan:
1. DEPTH=6, INDEX=3; reset, then push 0xA0..0xA5 over 6 cycles -> full_o=1, count_o=6. A 7th push of 0xA6 -> ram_we_o=0, overflow_o=1, count_o stays 6.
2. From full, pop 6 times -> pop_data_o reads 0xA0..0xA5 in order, then empty_o=1. ram_rd_addr_o wraps 5->0.
3. Full queue, push 0xB0 and pop in the same cycle -> pop_data_o=0xA0 that cycle, count_o stays 6, the entry at address 0 now holds 0xB0, and after 5 more pops pop_data_o=0xB0.
4. Empty queue, push 0x11 and pop together -> underflow_o=1, count_o=1, and the next cycle pop_data_o=0x11.
5. Push 3 entries, then flush_i together with push_i -> count_o=0, empty_o=1, ram_we_o=0 in the flush cycle, and sticky flags unchanged.
6. With QUEUE_ALMOST_FULL_EN defined and AF_THRESH=4, DEPTH=6: push 4 entries -> almost_full_o=1 after the 4th edge. Pop 1 -> almost_full_o=0. Pulse reset_n low -> almost_full_o=0 and empty_o=1 without waiting for a clock edge.
